// File: rtl/alu_arbiter_pkg.sv
// Shared ALU types: the opcode encoding and the flag bundle exchanged between
// requesters, the arbiter and the combinational ALU.
package alu_arbiter_pkg;

  typedef enum logic [2:0] {
    ALU_OP_AND    = 3'd0,
    ALU_OP_OR     = 3'd1,
    ALU_OP_XOR    = 3'd2,
    ALU_OP_ADD    = 3'd3,
    ALU_OP_SUB    = 3'd4,
    ALU_OP_MUL    = 3'd5,
    ALU_OP_DIV    = 3'd6,
    ALU_OP_PASS_A = 3'd7
  } enum_alu_opcode_t;

  typedef struct packed {
    logic carry;
    logic zero;
    logic negative;
    logic overflow;
  } struct_alu_flag_t;

endpackage

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ requesters:
// grant, hold registered operands for EXEC_CYCLES, then return a tagged response.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int EXEC_CYCLES = 1,
  localparam int ID_W       = $clog2(NUM_REQ),
  localparam int OP_W       = $bits(enum_alu_opcode_t)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]            req_carry,
  input  logic [NUM_REQ*OP_W-1:0]       req_opcode,
  input  logic [NUM_REQ-1:0]            req_mode,
  output logic [DATA_WIDTH-1:0]         alu_in_a,
  output logic [DATA_WIDTH-1:0]         alu_in_b,
  output logic                          alu_input_carry,
  output enum_alu_opcode_t              alu_opcode,
  output logic                          alu_mode,
  input  logic [DATA_WIDTH-1:0]         alu_out,
  input  struct_alu_flag_t              alu_out_flag,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [ID_W-1:0]               resp_id,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output struct_alu_flag_t              resp_flag,
  output logic                          busy
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t                state, state_next;
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       winner;
  logic [ID_W-1:0]       id_q;
  logic [ID_W:0]         scan_idx;
  logic                  grant_found;
  logic                  handshake;
  logic                  exec_done;
  logic [CNT_W-1:0]      exec_cnt;

  logic [DATA_WIDTH-1:0] a_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] b_arr  [NUM_REQ];
  enum_alu_opcode_t      op_arr [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      a_arr[i]  = req_a[i*DATA_WIDTH +: DATA_WIDTH];
      b_arr[i]  = req_b[i*DATA_WIDTH +: DATA_WIDTH];
      op_arr[i] = enum_alu_opcode_t'(req_opcode[i*OP_W +: OP_W]);
    end
  end

  // Scan upward from rr_ptr with wrap; the first pending requester wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    grant_found = 1'b0;
    winner      = '0;
    scan_idx    = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      scan_idx = {1'b0, rr_ptr} + (ID_W+1)'(off);
      if (scan_idx >= (ID_W+1)'(NUM_REQ)) begin
        scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
      end
      if (!grant_found && req_valid[scan_idx[ID_W-1:0]]) begin
        grant_found = 1'b1;
        winner      = scan_idx[ID_W-1:0];
      end
    end
  end

  assign handshake  = (state == S_IDLE) && grant_found;
  assign req_ready  = handshake ? (NUM_REQ'(1) << winner) : '0;
  assign exec_done  = (state == S_EXEC) && (exec_cnt == '0);
  assign resp_valid = (state == S_RESP);
  assign busy       = (state != S_IDLE);

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (handshake)  state_next = S_EXEC;
      S_EXEC:  if (exec_done)  state_next = S_RESP;
      S_RESP:  if (resp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ALU operand registers are only rewritten by the next grant, so the last
  // operation stays visible on the ALU after completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr          <= '0;
      id_q            <= '0;
      exec_cnt        <= '0;
      alu_in_a        <= '0;
      alu_in_b        <= '0;
      alu_input_carry <= 1'b0;
      alu_opcode      <= ALU_OP_AND;
      alu_mode        <= 1'b0;
      resp_id         <= '0;
      resp_data       <= '0;
      resp_flag       <= '0;
    end else if (handshake) begin
      // NOTE: non-blocking for all registered state so same-edge reads see pre-edge values.
      alu_in_a        <= a_arr[winner];
      alu_in_b        <= b_arr[winner];
      alu_input_carry <= req_carry[winner];
      alu_opcode      <= op_arr[winner];
      alu_mode        <= req_mode[winner];
      id_q            <= winner;
      exec_cnt        <= CNT_W'(EXEC_CYCLES - 1);
      rr_ptr          <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
    end else if (state == S_EXEC) begin
      if (exec_cnt == '0) begin
        resp_data <= alu_out;
        resp_flag <= alu_out_flag;
        resp_id   <= id_q;
      end else begin
        exec_cnt <= exec_cnt - CNT_W'(1);
      end
    end
  end

endmodule
